// File: rtl/huc6260_pkg.sv
// Shared constants and types for the HuC6260 video colour encoder.
// Register map, dot-clock select encoding and colour-word geometry.
package huc6260_pkg;

  localparam int unsigned ColorW     = 3;
  localparam int unsigned WordW      = 3 * ColorW;
  localparam int unsigned TableDepth = 512;
  localparam int unsigned AddrW      = 9;

  localparam logic [2:0] RegCr   = 3'd0;
  localparam logic [2:0] RegCtaL = 3'd2;
  localparam logic [2:0] RegCtaH = 3'd3;
  localparam logic [2:0] RegCtdL = 3'd4;
  localparam logic [2:0] RegCtdH = 3'd5;

  typedef enum logic [1:0] {
    DotDiv4    = 2'd0,
    DotDiv3    = 2'd1,
    DotDiv2    = 2'd2,
    DotDiv2Alt = 2'd3
  } dot_sel_e;

  function automatic logic [2:0] dot_divisor(dot_sel_e sel);
    logic [2:0] div;
    case (sel)
      DotDiv4: div = 3'd4;
      DotDiv3: div = 3'd3;
      default: div = 3'd2;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/huc6260_palette_ram.sv
// 512x9 colour table: CPU port with byte-lane synchronous write and async read,
// plus an independent async read port for the pixel path.
module huc6260_palette_ram
  import huc6260_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_lo_i,
  input  logic             we_hi_i,
  input  logic [AddrW-1:0] cpu_addr_i,
  input  logic [7:0]       wdata_lo_i,
  input  logic             wdata_hi_i,
  output logic [WordW-1:0] cpu_rdata_o,
  input  logic [AddrW-1:0] pix_addr_i,
  output logic [WordW-1:0] pix_rdata_o
);

  // No reset: table contents survive a reset of the encoder.
  logic [WordW-1:0] mem_q [TableDepth];

  always_ff @(posedge clk_i) begin
    if (we_lo_i) begin
      mem_q[cpu_addr_i][7:0] <= wdata_lo_i;
    end
    if (we_hi_i) begin
      mem_q[cpu_addr_i][8] <= wdata_hi_i;
    end
  end

  assign cpu_rdata_o = mem_q[cpu_addr_i];
  assign pix_rdata_o = mem_q[pix_addr_i];

endmodule

// File: rtl/huc6260_vce.sv
// HuC6260 video colour encoder: dot-clock divider, CPU register port and
// registered palette lookup of the VDC pixel stream.
module huc6260_vce
  import huc6260_pkg::*;
(
  input  logic       clock,
  input  logic       reset_N,
  input  logic [8:0] VD,
  input  logic       HSYN,
  input  logic       VSYN,
  input  logic [2:0] A,
  inout  wire  [7:0] D,
  input  logic       CS_n,
  input  logic       WR_n,
  input  logic       RD_n,
  output logic       clock_en,
  output logic [1:0] address_mode,
  output logic [2:0] VIDEO_R,
  output logic [2:0] VIDEO_G,
  output logic [2:0] VIDEO_B
);

  logic [7:0]       cr_q, cr_d;
  logic [AddrW-1:0] cta_q, cta_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_n_q, rd_n_q;
  logic [WordW-1:0] rgb_q, rgb_d;

  logic             write_evt, read_evt, read_act;
  logic             we_lo, we_hi;
  logic [2:0]       divisor;
  logic [AddrW-1:0] pix_idx;
  logic [WordW-1:0] cpu_rdata, pix_rdata;
  logic [7:0]       rd_data;
  logic             unused_cr;

  assign write_evt = !CS_n && !WR_n && wr_n_q;
  assign read_evt  = !CS_n && !RD_n && rd_n_q;
  assign read_act  = !CS_n && !RD_n;

  assign we_lo = write_evt && (A == RegCtdL);
  assign we_hi = write_evt && (A == RegCtdH);

  assign divisor      = dot_divisor(dot_sel_e'(cr_q[1:0]));
  assign clock_en     = ({1'b0, cnt_q} == (divisor - 3'd1));
  assign address_mode = cr_q[1:0];
  assign unused_cr    = ^cr_q[7:2];

  // Index 0 of each background palette mirrors the global background colour.
  assign pix_idx = (!VD[8] && (VD[3:0] == 4'd0)) ? '0 : VD;

  huc6260_palette_ram u_palette_ram (
    .clk_i       (clock),
    .we_lo_i     (we_lo),
    .we_hi_i     (we_hi),
    .cpu_addr_i  (cta_q),
    .wdata_lo_i  (D),
    .wdata_hi_i  (D[0]),
    .cpu_rdata_o (cpu_rdata),
    .pix_addr_i  (pix_idx),
    .pix_rdata_o (pix_rdata)
  );

  always_comb begin
    cr_d  = cr_q;
    cta_d = cta_q;
    cnt_d = clock_en ? 2'd0 : cnt_q + 2'd1;
    if (write_evt) begin
      case (A)
        RegCr: begin
          cr_d  = D;
          cnt_d = 2'd0;
        end
        RegCtaL: cta_d[7:0] = D;
        RegCtaH: cta_d[8]   = D[0];
        RegCtdH: cta_d      = cta_q + 9'd1;
        default: ;
      endcase
    end
    if (read_evt && (A == RegCtdH)) begin
      cta_d = cta_q + 9'd1;
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    if (clock_en) begin
      rgb_d = (HSYN && VSYN) ? pix_rdata : '0;
    end
  end

  always_comb begin
    case (A)
      RegCtdL: rd_data = cpu_rdata[7:0];
      RegCtdH: rd_data = {7'h7F, cpu_rdata[8]};
      default: rd_data = 8'hFF;
    endcase
  end

  assign D = read_act ? rd_data : 8'hzz;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      cr_q   <= '0;
      cta_q  <= '0;
      cnt_q  <= '0;
      wr_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      rgb_q  <= '0;
    end else begin
      cr_q   <= cr_d;
      cta_q  <= cta_d;
      cnt_q  <= cnt_d;
      wr_n_q <= WR_n;
      rd_n_q <= RD_n;
      rgb_q  <= rgb_d;
    end
  end

  assign VIDEO_G = rgb_q[8:6];
  assign VIDEO_R = rgb_q[5:3];
  assign VIDEO_B = rgb_q[2:0];

endmodule

// File: tb/tb_huc6260_vce.sv
// Self-checking bench for huc6260_vce: directed steps plus randomized traffic
// compared against a cycle-level behavioural model of the encoder.
module tb_huc6260_vce;

  logic       clock = 1'b0;
  logic       reset_N;
  logic [8:0] VD;
  logic       HSYN, VSYN;
  logic [2:0] A;
  logic       CS_n, WR_n, RD_n;
  logic [7:0] d_drv;
  logic       d_oe;
  wire  [7:0] D;
  logic       clock_en;
  logic [1:0] address_mode;
  logic [2:0] VIDEO_R, VIDEO_G, VIDEO_B;

  assign D = d_oe ? d_drv : 8'hzz;

  huc6260_vce dut (
    .clock        (clock),
    .reset_N      (reset_N),
    .VD           (VD),
    .HSYN         (HSYN),
    .VSYN         (VSYN),
    .A            (A),
    .D            (D),
    .CS_n         (CS_n),
    .WR_n         (WR_n),
    .RD_n         (RD_n),
    .clock_en     (clock_en),
    .address_mode (address_mode),
    .VIDEO_R      (VIDEO_R),
    .VIDEO_G      (VIDEO_G),
    .VIDEO_B      (VIDEO_B)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [8:0] m_tbl [512];
  logic [7:0] m_cr;
  logic [8:0] m_cta;
  int         m_t;      // cycles since the divider last restarted
  logic [8:0] m_rgb;    // {G,R,B}
  logic       m_wr_prev, m_rd_prev;
  logic       last_en;
  logic [7:0] last_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] sel);
    if (sel == 2'd0) return 4;
    if (sel == 2'd1) return 3;
    return 2;
  endfunction

  function automatic logic [7:0] read_exp();
    if (A == 3'd4) return m_tbl[m_cta][7:0];
    if (A == 3'd5) return {7'h7F, m_tbl[m_cta][8]};
    return 8'hFF;
  endfunction

  task automatic model_reset();
    m_cr = 8'h00; m_cta = 9'h000; m_t = 0; m_rgb = 9'h000;
    m_wr_prev = 1'b1; m_rd_prev = 1'b1;
  endtask

  // One clock: check pre-edge outputs, advance the model, check registered RGB.
  task automatic step();
    int n;
    logic wr_ev, rd_ev;
    logic [8:0] idx;
    @(negedge clock); #4;
    n = div_of(m_cr[1:0]);
    last_en = ((m_t % n) == n - 1);
    check("clock_en", clock_en, last_en);
    check("address_mode", address_mode, m_cr[1:0]);
    if (!CS_n && !RD_n) begin
      last_d = D;
      check("read_data", D, read_exp());
    end
    wr_ev = !CS_n && !WR_n && m_wr_prev;
    rd_ev = !CS_n && !RD_n && m_rd_prev;
    if (last_en) begin
      idx = (!VD[8] && VD[3:0] == 4'd0) ? 9'd0 : VD;
      m_rgb = (HSYN && VSYN) ? m_tbl[idx] : 9'd0;
    end
    m_t = m_t + 1;
    if (wr_ev) begin
      case (A)
        3'd0: begin m_cr = d_drv; m_t = 0; end
        3'd2: m_cta[7:0] = d_drv;
        3'd3: m_cta[8] = d_drv[0];
        3'd4: m_tbl[m_cta][7:0] = d_drv;
        3'd5: begin m_tbl[m_cta][8] = d_drv[0]; m_cta = (m_cta + 9'd1) % 512; end
        default: ;
      endcase
    end
    if (rd_ev && A == 3'd5) m_cta = (m_cta + 9'd1) % 512;
    m_wr_prev = WR_n;
    m_rd_prev = RD_n;
    @(posedge clock); #1;
    check("rgb", {VIDEO_G, VIDEO_R, VIDEO_B}, m_rgb);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    A = a; d_drv = d; d_oe = 1'b1; CS_n = 1'b0; WR_n = 1'b0;
    step();
    CS_n = 1'b1; WR_n = 1'b1; d_oe = 1'b0;
    step();
  endtask

  task automatic cpu_read(input logic [2:0] a);
    A = a; CS_n = 1'b0; RD_n = 1'b0;
    step();
    CS_n = 1'b1; RD_n = 1'b1;
    step();
  endtask

  task automatic set_cta(input logic [8:0] v);
    cpu_write(3'd2, v[7:0]);
    cpu_write(3'd3, {7'd0, v[8]});
  endtask

  task automatic wait_pulse();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = last_en;
    end
    check("pulse_seen", seen, 1'b1);
  endtask

  initial begin
    reset_N = 1'b0; VD = 9'h000; HSYN = 1'b0; VSYN = 1'b1; A = 3'd0;
    CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1; d_drv = 8'h00; d_oe = 1'b0;
    last_en = 1'b0; last_d = 8'h00;
    model_reset();
    #12;
    check("reset_clock_en", clock_en, 1'b0);
    check("reset_rgb", {VIDEO_G, VIDEO_R, VIDEO_B}, 9'h000);
    check("reset_address_mode", address_mode, 2'd0);
    @(posedge clock); #1;
    reset_N = 1'b1;

    // Idle: divide by 4, first pulse on cycle 4
    for (int i = 0; i < 12; i++) step();

    // Dot-clock changes
    cpu_write(3'd0, 8'h01);
    for (int i = 0; i < 9; i++) step();
    cpu_write(3'd0, 8'h02);
    for (int i = 0; i < 8; i++) step();

    // Fill the table with random contents (sync off so RGB stays 0)
    set_cta(9'h000);
    for (int i = 0; i < 512; i++) begin
      cpu_write(3'd4, 8'($urandom));
      cpu_write(3'd5, 8'($urandom));
    end

    // Wrap of CTA at 0x1FF and readback
    set_cta(9'h1FF);
    cpu_write(3'd4, 8'hA5);
    cpu_write(3'd5, 8'h01);
    cpu_read(3'd4);
    check("wrap_read_entry0", last_d, m_tbl[0][7:0]);
    set_cta(9'h1FF);
    cpu_read(3'd4);
    check("read_ctd_lo_1ff", last_d, 8'hA5);
    cpu_read(3'd5);
    check("read_ctd_hi_1ff", last_d, 8'hFF);
    cpu_read(3'd1);
    check("read_other", last_d, 8'hFF);

    // Direct lookup
    set_cta(9'h123);
    cpu_write(3'd4, 8'hC7);
    cpu_write(3'd5, 8'h01);
    HSYN = 1'b1; VSYN = 1'b1; VD = 9'h123;
    wait_pulse();
    check("lut_123_g", VIDEO_G, 3'd7);
    check("lut_123_r", VIDEO_R, 3'd0);
    check("lut_123_b", VIDEO_B, 3'd7);

    // Background mirror
    set_cta(9'h000);
    cpu_write(3'd4, 8'h07);
    cpu_write(3'd5, 8'h00);
    set_cta(9'h010);
    cpu_write(3'd4, 8'hFF);
    cpu_write(3'd5, 8'h01);
    set_cta(9'h110);
    cpu_write(3'd4, 8'hA3);
    cpu_write(3'd5, 8'h00);
    VD = 9'h010;
    wait_pulse();
    check("mirror_rgb", {VIDEO_G, VIDEO_R, VIDEO_B}, 9'h007);
    VD = 9'h110;
    wait_pulse();
    check("sprite_110_rgb", {VIDEO_G, VIDEO_R, VIDEO_B}, 9'h0A3);

    // Blanking, then asynchronous reset mid-line
    VSYN = 1'b0;
    wait_pulse();
    check("vsync_blank", {VIDEO_G, VIDEO_R, VIDEO_B}, 9'h000);
    VSYN = 1'b1;
    wait_pulse();
    step();
    #2;
    reset_N = 1'b0;
    #1;
    check("async_rst_rgb", {VIDEO_G, VIDEO_R, VIDEO_B}, 9'h000);
    check("async_rst_clock_en", clock_en, 1'b0);
    model_reset();
    @(posedge clock); #1;
    reset_N = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      VD   = 9'($urandom);
      HSYN = ($urandom_range(0, 7) != 0);
      VSYN = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 11))
        0: cpu_write(3'd0, 8'($urandom));
        1: set_cta(9'($urandom));
        2: cpu_write(3'd4, 8'($urandom));
        3: cpu_write(3'd5, 8'($urandom));
        4: cpu_read(3'($urandom_range(4, 5)));
        5: cpu_read(3'($urandom));
        6: cpu_write(3'($urandom_range(6, 7)), 8'($urandom));
        default: step();
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
